muldiv_seq: RTL

Iterative RV32M multiply/divide sequencer beside the single-cycle ALU. The main control unit issues a MUL/DIV/REM-class instruction to this block and stalls the pipeline while `busy_o` is high. The block runs a 32-step shift-add multiply or restoring divide, then returns a 32-bit result for register write-back.

---
 rtl/muldiv_seq.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// Purpose: iterative RV32M multiply/divide sequencer (shift-add multiply, restoring divide); early-out build macro: MULDIV_EARLY_OUT_EN.
// Latency: start_i in cycle 0 -> done_o in cycle 33; div-by-zero/overflow take 1 cycle when MULDIV_EARLY_OUT_EN is defined.
// Backpressure: none; busy_o stalls the issuer, start_i is sampled only in IDLE, nothing is queued.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state, state_nxt;
  logic [2:0]      op;
  logic [5:0]      cnt;
  logic [XLEN-1:0] hi, lo, opb;
  logic            neg, special;
  logic [XLEN-1:0] special_val;

  logic            is_div_in, a_sgn_in, b_sgn_in, a_neg_in, b_neg_in;
  logic            neg_in, div0_in, ovf_in, special_in;
  logic [XLEN-1:0] a_mag_in, b_mag_in, special_val_in;

  logic            accept, last_step;

  logic [XLEN:0]     sum, shifted;
  logic              ge;
  logic [XLEN-1:0]   diff, hi_nxt, lo_nxt, div_sel, div_res, calc_res;
  logic [2*XLEN-1:0] prod;

  // Issue-time decode: operand signedness, magnitudes, result sign and RISC-V special cases.
  always_comb begin
    is_div_in = funct3_i[2];
    // MULH and MULHSU take rs1 as signed; MUL low half is sign-agnostic so it runs unsigned.
    a_sgn_in  = is_div_in ? ~funct3_i[0] : (funct3_i[1] ^ funct3_i[0]);
    b_sgn_in  = is_div_in ? ~funct3_i[0] : (funct3_i[1:0] == 2'b01);
    a_neg_in  = a_sgn_in & rs1_i[XLEN-1];
    b_neg_in  = b_sgn_in & rs2_i[XLEN-1];
    a_mag_in  = a_neg_in ? -rs1_i : rs1_i;
    b_mag_in  = b_neg_in ? -rs2_i : rs2_i;
    // Remainder follows the dividend sign; quotient and product follow the sign xor.
    neg_in    = (is_div_in & funct3_i[1]) ? a_neg_in : (a_neg_in ^ b_neg_in);
    div0_in   = is_div_in & (rs2_i == '0);
    ovf_in    = is_div_in & ~funct3_i[0] & (rs1_i == INT_MIN) & (rs2_i == '1);
    special_in = div0_in | ovf_in;
    special_val_in = '0;
    if (div0_in) begin
      special_val_in = funct3_i[1] ? rs1_i : '1;
    end else if (ovf_in) begin
      special_val_in = funct3_i[1] ? '0 : INT_MIN;
    end
  end

  // One iteration step plus the sign-corrected result that would land if this is the last step.
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    shifted = {hi, lo[XLEN-1]};
    ge      = (shifted >= {1'b0, opb});
    // Only the low word of the difference survives: when ge holds it is below the divisor.
    diff    = shifted[XLEN-1:0] - opb;
    if (op[2]) begin
      hi_nxt = ge ? diff : shifted[XLEN-1:0];
      lo_nxt = {lo[XLEN-2:0], ge};
    end else begin
      hi_nxt = sum[XLEN:1];
      lo_nxt = {sum[0], lo[XLEN-1:1]};
    end
    prod     = neg ? -{hi_nxt, lo_nxt} : {hi_nxt, lo_nxt};
    div_sel  = op[1] ? hi_nxt : lo_nxt;
    div_res  = neg ? -div_sel : div_sel;
    calc_res = op[2] ? div_res
             : ((op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_step = 1'b0;
    busy_o    = (state != IDLE);
    done_o    = (state == DONE);
    case (state)
      IDLE: begin
        if (start_i && !kill_i) begin
          accept = 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
          state_nxt = special_in ? DONE : CALC;
`else
          state_nxt = CALC;
`endif
        end
      end
      CALC: begin
        if (kill_i) begin
          state_nxt = IDLE;
        end else if (cnt == 6'(XLEN-1)) begin
          last_step = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, iterate in CALC, write the result on entry to DONE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op          <= '0;
      cnt         <= '0;
      hi          <= '0;
      lo          <= '0;
      opb         <= '0;
      neg         <= 1'b0;
      special     <= 1'b0;
      special_val <= '0;
      result_o    <= '0;
    end else if (accept) begin
      op          <= funct3_i;
      cnt         <= '0;
      hi          <= '0;
      // Divide shifts the dividend out of lo; multiply shifts the multiplier out of lo.
      lo          <= funct3_i[2] ? a_mag_in : b_mag_in;
      opb         <= funct3_i[2] ? b_mag_in : a_mag_in;
      neg         <= neg_in;
      special     <= special_in;
      special_val <= special_val_in;
`ifdef MULDIV_EARLY_OUT_EN
      if (special_in) begin
        result_o <= special_val_in;
      end
`endif
    end else if (state == CALC) begin
      hi  <= hi_nxt;
      lo  <= lo_nxt;
      cnt <= cnt + 6'd1;
      if (last_step) begin
        result_o <= special ? special_val : calc_res;
      end
    end
  end

endmodule
